// File: rtl/fetch_sequencer_if.sv
// Control bundle between the fetch sequencer and the core top level / hazard unit / PC datapath.
// The master side raises requests and execute-stage events; the slave side is the sequencer.

interface fetch_sequencer_if #(
    parameter int CNT_WIDTH = 16
) ();
    logic                 trigger;
    logic                 stall_f;
    logic                 br_taken_e;
    logic                 jal_e;
    logic                 jalr_e;
    logic                 halt_e;

    logic [1:0]           pcsrc;
    logic                 pc_trigger;
    logic                 pc_en;
    logic                 flush_d;
    logic                 flush_e;
    logic                 running;
    logic [CNT_WIDTH-1:0] redirect_cnt;

    modport master (
        output trigger, stall_f, br_taken_e, jal_e, jalr_e, halt_e,
        input  pcsrc, pc_trigger, pc_en, flush_d, flush_e, running, redirect_cnt
    );

    modport slave (
        input  trigger, stall_f, br_taken_e, jal_e, jalr_e, halt_e,
        output pcsrc, pc_trigger, pc_en, flush_d, flush_e, running, redirect_cnt
    );
endinterface

// File: rtl/fetch_sequencer.sv
// PC-path controller: start/stop, execute-stage redirect arbitration against stalls,
// wrong-path flushing, halt, and a saturating count of accepted redirects.

module fetch_sequencer #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_sequencer_if.slave  bus
);

    localparam int FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_HALT
    } state_t;

    typedef enum logic [1:0] {
        SRC_PLUS4  = 2'b00,
        SRC_TARGET = 2'b01,
        SRC_ALU    = 2'b10
    } pcsrc_t;

    state_t               state_q, state_d;
    logic [FL_W-1:0]      flush_left_q, flush_left_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    pcsrc_t pcsrc;
    logic   pc_trigger;
    logic   pc_en;
    logic   flush_d;
    logic   flush_e;
    logic   running;
    logic   redir;

    assign redir = bus.jalr_e | bus.jal_e | bus.br_taken_e;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            flush_left_q <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            flush_left_q <= flush_left_d;
            cnt_q        <= cnt_d;
        end
    end

    // NOTE: every output and next-state value gets a default first so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        flush_left_d = flush_left_q;
        cnt_d        = cnt_q;
        pcsrc        = SRC_PLUS4;
        pc_trigger   = 1'b0;
        pc_en        = 1'b1;
        flush_d      = 1'b0;
        flush_e      = 1'b0;
        running      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // pc_mux holds PC at 0 while its trigger is low, so loading is harmless.
                if (bus.trigger) begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                pc_trigger = 1'b1;
                running    = 1'b1;
                if (bus.halt_e) begin
                    pc_en   = 1'b0;
                    state_d = S_HALT;
                end else begin
                    if (redir) begin
                        pcsrc        = bus.jalr_e ? SRC_ALU : SRC_TARGET;
                        pc_en        = 1'b1;
                        flush_d      = 1'b1;
                        flush_e      = 1'b1;
                        flush_left_d = FL_W'(FLUSH_CYCLES - 1);
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + CNT_WIDTH'(1);
                        end
                        if (FLUSH_CYCLES > 1) begin
                            state_d = S_FLUSH;
                        end
                    end else begin
                        pc_en = !bus.stall_f;
                    end
                    if (!bus.trigger) begin
                        state_d      = S_IDLE;
                        flush_left_d = '0;
                    end
                end
            end

            S_FLUSH: begin
                // Instructions now in decode/execute are wrong-path: their redirects and halts are dropped.
                pc_trigger = 1'b1;
                running    = 1'b1;
                pc_en      = !bus.stall_f;
                flush_d    = 1'b1;
                if (!bus.trigger) begin
                    state_d      = S_IDLE;
                    flush_left_d = '0;
                end else if (flush_left_q <= FL_W'(1)) begin
                    state_d      = S_RUN;
                    flush_left_d = '0;
                end else begin
                    flush_left_d = flush_left_q - FL_W'(1);
                end
            end

            S_HALT: begin
                pc_trigger = 1'b1;
                pc_en      = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.pcsrc        = pcsrc;
    assign bus.pc_trigger   = pc_trigger;
    assign bus.pc_en        = pc_en;
    assign bus.flush_d      = flush_d;
    assign bus.flush_e      = flush_e;
    assign bus.running      = running;
    assign bus.redirect_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench: two sequencer configurations share one stimulus stream; a reference model
// pushes expected outputs per cycle and a negedge monitor pops and compares them.

module tb_fetch_sequencer;

    localparam int FC_A = 2;
    localparam int CW_A = 16;
    localparam int FC_B = 3;
    localparam int CW_B = 2;

    logic clk;
    logic rst_n;
    logic trigger, stall_f, br_taken_e, jal_e, jalr_e, halt_e;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [1:0] pcsrc;
        logic       pc_trigger;
        logic       pc_en;
        logic       flush_d;
        logic       flush_e;
        logic       running;
        int         cnt;
    } exp_t;

    // Model view: active = started and not stopped, ignore_left = wrong-path cycles still to drop.
    typedef struct {
        bit active;
        bit halted;
        int ignore_left;
        int count;
    } mdl_t;

    exp_t q_a[$];
    exp_t q_b[$];
    mdl_t m_a = '{active: 1'b0, halted: 1'b0, ignore_left: 0, count: 0};
    mdl_t m_b = '{active: 1'b0, halted: 1'b0, ignore_left: 0, count: 0};

    fetch_sequencer_if #(.CNT_WIDTH(CW_A)) bus_a ();
    fetch_sequencer_if #(.CNT_WIDTH(CW_B)) bus_b ();

    assign bus_a.trigger    = trigger;
    assign bus_a.stall_f    = stall_f;
    assign bus_a.br_taken_e = br_taken_e;
    assign bus_a.jal_e      = jal_e;
    assign bus_a.jalr_e     = jalr_e;
    assign bus_a.halt_e     = halt_e;
    assign bus_b.trigger    = trigger;
    assign bus_b.stall_f    = stall_f;
    assign bus_b.br_taken_e = br_taken_e;
    assign bus_b.jal_e      = jal_e;
    assign bus_b.jalr_e     = jalr_e;
    assign bus_b.halt_e     = halt_e;

    fetch_sequencer #(.FLUSH_CYCLES(FC_A), .CNT_WIDTH(CW_A)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    fetch_sequencer #(.FLUSH_CYCLES(FC_B), .CNT_WIDTH(CW_B)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic void model_step(input mdl_t s, input int fc, input int cmax,
                                       output exp_t e, output mdl_t n);
        bit redir;
        n = s;
        e = '{pcsrc: 2'b00, pc_trigger: 1'b0, pc_en: 1'b1, flush_d: 1'b0,
              flush_e: 1'b0, running: 1'b0, cnt: s.count};
        redir = br_taken_e | jal_e | jalr_e;
        if (!rst_n) begin
            n     = '{active: 1'b0, halted: 1'b0, ignore_left: 0, count: 0};
            e.cnt = 0;
        end else if (s.halted) begin
            e.pc_trigger = 1'b1;
            e.pc_en      = 1'b0;
        end else if (!s.active) begin
            n.active = trigger;
        end else begin
            e.pc_trigger = 1'b1;
            e.running    = 1'b1;
            if (s.ignore_left > 0) begin
                e.pc_en   = !stall_f;
                e.flush_d = 1'b1;
                if (!trigger) begin
                    n.active      = 1'b0;
                    n.ignore_left = 0;
                end else begin
                    n.ignore_left = s.ignore_left - 1;
                end
            end else if (halt_e) begin
                e.pc_en  = 1'b0;
                n.halted = 1'b1;
            end else begin
                if (redir) begin
                    e.pcsrc       = jalr_e ? 2'b10 : 2'b01;
                    e.pc_en       = 1'b1;
                    e.flush_d     = 1'b1;
                    e.flush_e     = 1'b1;
                    n.count       = (s.count < cmax) ? s.count + 1 : cmax;
                    n.ignore_left = fc - 1;
                end else begin
                    e.pc_en = !stall_f;
                end
                if (!trigger) begin
                    n.active      = 1'b0;
                    n.ignore_left = 0;
                end
            end
        end
    endfunction

    // Apply one cycle of stimulus just after the rising edge and queue what both DUTs must show.
    task automatic drive(input logic r, input logic t, input logic s, input logic br,
                         input logic j, input logic jr, input logic h);
        exp_t e;
        mdl_t n;
        @(posedge clk);
        #1;
        rst_n      = r;
        trigger    = t;
        stall_f    = s;
        br_taken_e = br;
        jal_e      = j;
        jalr_e     = jr;
        halt_e     = h;
        model_step(m_a, FC_A, (1 << CW_A) - 1, e, n);
        q_a.push_back(e);
        m_a = n;
        model_step(m_b, FC_B, (1 << CW_B) - 1, e, n);
        q_b.push_back(e);
        m_b = n;
    endtask

    task automatic compare(input string tag, input exp_t e, input logic [1:0] pcsrc,
                           input logic pc_trigger, input logic pc_en, input logic flush_d,
                           input logic flush_e, input logic running, input logic [31:0] cnt);
        check({tag, ".pcsrc"},        32'(pcsrc),      32'(e.pcsrc));
        check({tag, ".pc_trigger"},   32'(pc_trigger), 32'(e.pc_trigger));
        check({tag, ".pc_en"},        32'(pc_en),      32'(e.pc_en));
        check({tag, ".flush_d"},      32'(flush_d),    32'(e.flush_d));
        check({tag, ".flush_e"},      32'(flush_e),    32'(e.flush_e));
        check({tag, ".running"},      32'(running),    32'(e.running));
        check({tag, ".redirect_cnt"}, cnt,             32'(e.cnt));
    endtask

    always @(negedge clk) begin
        if (q_a.size() > 0) begin
            compare("dut_a", q_a.pop_front(), bus_a.pcsrc, bus_a.pc_trigger, bus_a.pc_en,
                    bus_a.flush_d, bus_a.flush_e, bus_a.running, 32'(bus_a.redirect_cnt));
        end
        if (q_b.size() > 0) begin
            compare("dut_b", q_b.pop_front(), bus_b.pcsrc, bus_b.pc_trigger, bus_b.pc_en,
                    bus_b.flush_d, bus_b.flush_e, bus_b.running, 32'(bus_b.redirect_cnt));
        end
        cyc++;
    end

    initial begin
        rst_n = 1'b0; trigger = 1'b0; stall_f = 1'b0;
        br_taken_e = 1'b0; jal_e = 1'b0; jalr_e = 1'b0; halt_e = 1'b0;

        // Reset, then start with trigger on the third released cycle.
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0);

        // Three stalled cycles, then a branch on a stalled cycle.
        for (int i = 0; i < 3; i++) drive(1, 1, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 0, 0, 0);

        // Wrong-path jalr right after a jal, then jal+jalr together.
        drive(1, 1, 0, 0, 1, 0, 0);
        drive(1, 1, 0, 0, 0, 1, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) drive(1, 1, 1, 0, 0, 0, 0);

        // Trigger drop returns to idle; restart.
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0);

        // Five spaced redirects: the 2-bit counter pins at 3.
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 1, 0, 0, 0);
            for (int k = 0; k < 4; k++) drive(1, 1, 0, 0, 0, 0, 0);
        end

        // Async reset landing inside a flush window.
        drive(1, 1, 0, 0, 1, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0);

        // Halt beats a simultaneous branch and holds through trigger toggling.
        drive(1, 1, 1, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) drive(1, i[0], i[1], 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic with occasional halts and reset pulses.
        for (int i = 0; i < 600; i++) begin
            logic r, t, s, br, j, jr, h;
            r  = ($urandom_range(0, 99) >= 2);
            t  = ($urandom_range(0, 99) >= 4);
            s  = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 9) == 0);
            j  = ($urandom_range(0, 9) == 0);
            jr = ($urandom_range(0, 9) == 0);
            h  = ($urandom_range(0, 199) < 3);
            if (!t) begin
                br = 1'b0; j = 1'b0; jr = 1'b0;
            end
            drive(r, t, s, br, j, jr, h);
        end

        drive(1, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        check("queue_a_drained", 32'(q_a.size()), 32'd0);
        check("queue_b_drained", 32'(q_b.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
